// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler.
//   sched_state_t : scheduler FSM encoding (IDLE=0 .. DONE=4)
//   STALL_CNT_W   : width of the optional write-stall counter
//   sat_inc       : saturating increment used by that counter
package layer_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  localparam int STALL_CNT_W = 16;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/layer_scheduler_index_counter.sv
// index_counter: modulo-MAX index register used for the input and neuron
// selects of the layer scheduler.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (count -> 0)
//   en        - global enable; the count holds when low
//   clear     - synchronous return to 0 (wins over inc)
//   inc       - advance by one; wraps to 0 after MAX-1
//   cnt       - current index
//   last      - cnt == MAX-1
module index_counter #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] LAST_VAL = W'(MAX - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clear) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/layer_scheduler.sv
// layer_scheduler: sequences one MAC datapath over NUM_NEURONS neurons of
// NUM_INPUTS inputs each. Per neuron: one BIAS cycle (adder loads bias),
// NUM_INPUTS MAC cycles (in_addr 0..NUM_INPUTS-1), then WRITE until the sink
// accepts the result. A DONE cycle pulses done and returns to IDLE.
//
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   clk_en     - global enable; state, counters and outputs hold when low
//   start      - evaluate the layer (honoured only in IDLE)
//   wr_ready   - result sink can accept a neuron result
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse when the layer completes
//   in_addr    - input/weight select for the MAC
//   neu_addr   - neuron select (weight bank, bias, result slot)
//   use_bias   - adder takes bias instead of product
//   acc_clr    - synchronous accumulator clear
//   wr_en      - write accumulator result into slot neu_addr
//   state_dbg  - current FSM state, for observation
//   stall_cnt  - (only with LAYER_SCHEDULER_STALL_CNT_EN) saturating count of
//                enabled cycles spent in WRITE with wr_ready low; cleared when
//                start is accepted and on rst
//
// Result handshake: a result transfers in a cycle where wr_en and wr_ready
// are both high (with clk_en high). wr_en only rises in WRITE and simply
// mirrors wr_ready there; while wr_ready is low the scheduler waits in WRITE
// with accumulator and addresses untouched.
//
// Build option: define LAYER_SCHEDULER_STALL_CNT_EN to add stall_cnt.
module layer_scheduler
  import layer_sched_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_NEURONS = 2,
  parameter int IN_AW       = 1,
  parameter int NEU_AW      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              start,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  output logic [NEU_AW-1:0] neu_addr,
  output logic              use_bias,
  output logic              acc_clr,
  output logic              wr_en,
  output sched_state_t      state_dbg
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  sched_state_t state, state_nxt;

  logic in_clr, in_inc, in_last;
  logic neu_clr, neu_inc, neu_last;
  logic start_acc;
  logic write_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_clr    = 1'b0;
    in_inc    = 1'b0;
    neu_clr   = 1'b0;
    neu_inc   = 1'b0;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        in_clr  = 1'b1;
        neu_clr = 1'b1;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = BIAS;
        end
      end
      BIAS: state_nxt = MAC;
      MAC: begin
        // in_addr wraps to 0 on its last step, ready for the next neuron.
        in_inc = 1'b1;
        if (in_last) state_nxt = WRITE;
      end
      WRITE: begin
        if (wr_ready) begin
          if (neu_last) begin
            state_nxt = DONE;
          end else begin
            neu_inc   = 1'b1;
            state_nxt = BIAS;
          end
        end
      end
      DONE: begin
        neu_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  index_counter #(.MAX(NUM_INPUTS), .W(IN_AW)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (clk_en),
    .clear (in_clr),
    .inc   (in_inc),
    .cnt   (in_addr),
    .last  (in_last)
  );

  index_counter #(.MAX(NUM_NEURONS), .W(NEU_AW)) u_neu_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (clk_en),
    .clear (neu_clr),
    .inc   (neu_inc),
    .cnt   (neu_addr),
    .last  (neu_last)
  );

  // The write strobe is qualified by clk_en so a frozen scheduler never
  // issues a write it will not also account for by advancing.
  assign write_fire = (state == WRITE) && wr_ready && clk_en;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign use_bias  = (state == BIAS);
  assign acc_clr   = (state == IDLE) || write_fire;
  assign wr_en     = write_fire;
  assign state_dbg = state;

`ifdef LAYER_SCHEDULER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (clk_en) begin
      if (start_acc) begin
        stall_q <= '0;
      end else if ((state == WRITE) && !wr_ready) begin
        stall_q <= sat_inc(stall_q);
      end
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: a 3-input/2-neuron instance checked cycle by
// cycle from a vector table plus multi-cycle sequences (write stall, clock
// freeze, reset mid-layer), and a 1-input/1-neuron instance.
module tb_layer_scheduler;
  import layer_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic start;
  logic start_s;
  logic wr_ready;

  always #5 clk = ~clk;

  // ---------------- DUT A: 3 inputs, 2 neurons ----------------
  logic         busy_a, done_a, ub_a, clr_a, wen_a;
  logic [1:0]   in_a;
  logic [0:0]   neu_a;
  sched_state_t st_a;
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
  logic [15:0]  stall_a;
`endif

  layer_scheduler #(
    .NUM_INPUTS (3),
    .NUM_NEURONS(2),
    .IN_AW      (2),
    .NEU_AW     (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .start    (start),
    .wr_ready (wr_ready),
    .busy     (busy_a),
    .done     (done_a),
    .in_addr  (in_a),
    .neu_addr (neu_a),
    .use_bias (ub_a),
    .acc_clr  (clr_a),
    .wr_en    (wen_a),
    .state_dbg(st_a)
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
    ,
    .stall_cnt(stall_a)
`endif
  );

  // ---------------- DUT S: 1 input, 1 neuron ----------------
  logic         busy_s, done_s, ub_s, clr_s, wen_s;
  logic [0:0]   in_s;
  logic [0:0]   neu_s;
  sched_state_t st_s;
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
  logic [15:0]  stall_s;
`endif

  layer_scheduler #(
    .NUM_INPUTS (1),
    .NUM_NEURONS(1),
    .IN_AW      (1),
    .NEU_AW     (1)
  ) dut_s (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .start    (start_s),
    .wr_ready (wr_ready),
    .busy     (busy_s),
    .done     (done_s),
    .in_addr  (in_s),
    .neu_addr (neu_s),
    .use_bias (ub_s),
    .acc_clr  (clr_s),
    .wr_en    (wen_s),
    .state_dbg(st_s)
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
    ,
    .stall_cnt(stall_s)
`endif
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state"},   int'(st_a),   int'(IDLE));
    check({tag, " busy"},    int'(busy_a), 0);
    check({tag, " done"},    int'(done_a), 0);
    check({tag, " in_addr"}, int'(in_a),   0);
    check({tag, " neu"},     int'(neu_a),  0);
    check({tag, " bias"},    int'(ub_a),   0);
    check({tag, " wr_en"},   int'(wen_a),  0);
    check({tag, " acc_clr"}, int'(clr_a),  1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         start;
    logic         wr_ready;
    logic         clk_en;
    sched_state_t st;
    logic         busy;
    logic         done;
    logic [1:0]   in_a;
    logic         neu;
    logic         chk_neu;
    logic         ub;
    logic         clr;
    logic         wen;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input bit s, input sched_state_t st, input bit b,
                              input bit d, input int ia, input int na,
                              input bit ub, input bit clr, input bit wen);
    vec_t r;
    r.start    = s;
    r.wr_ready = 1'b1;
    r.clk_en   = 1'b1;
    r.st       = st;
    r.busy     = b;
    r.done     = d;
    r.in_a     = 2'(ia);
    r.neu      = (na > 0);
    r.chk_neu  = (na >= 0);
    r.ub       = ub;
    r.clr      = clr;
    r.wen      = wen;
    return r;
  endfunction

  // ---------------- driver: one layer on DUT A ----------------
  // Drives start in cycle 0 and returns the cycle in which done is seen.
  // wr_ready is low in [stall_at, stall_at+stall_len); clk_en low in
  // [frz_at, frz_at+frz_len), during which in_addr must stay frz_in.
  task automatic run_layer(input int stall_at, input int stall_len,
                           input int frz_at, input int frz_len,
                           input int frz_in, output int cyc);
    bit fin;
    @(negedge clk);
    start    = 1'b1;
    wr_ready = 1'b1;
    clk_en   = 1'b1;
    cyc      = 0;
    fin      = 1'b0;
    while (!fin) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      wr_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      clk_en   = !(cyc >= frz_at && cyc < frz_at + frz_len);
      #1;
      if (!wr_ready) begin
        check("stall state",   int'(st_a),  int'(WRITE));
        check("stall wr_en",   int'(wen_a), 0);
        check("stall acc_clr", int'(clr_a), 0);
        check("stall neu",     int'(neu_a), 0);
      end
      if (!clk_en) begin
        check("freeze state",   int'(st_a), int'(MAC));
        check("freeze in_addr", int'(in_a), frz_in);
      end
      if (done_a) begin
        fin = 1'b1;
      end else if (cyc >= 100) begin
        check("done timeout", 0, 1);
        fin = 1'b1;
      end
    end
    @(negedge clk);
    wr_ready = 1'b1;
    clk_en   = 1'b1;
    #1;
    check("done single pulse", int'(done_a), 0);
    check("idle after done",   int'(st_a),   int'(IDLE));
    check("neu back to 0",     int'(neu_a),  0);
  endtask

  // ---------------- test ----------------
  int cyc;
  int done_pulses;
  sched_state_t exp_s[5];

  initial begin
    rst      = 1'b1;
    clk_en   = 1'b1;
    start    = 1'b0;
    start_s  = 1'b0;
    wr_ready = 1'b1;

    // start  state   busy done in  neu bias clr wen
    vecs[0]  = mk(1'b1, IDLE,  1'b0, 1'b0, 0,  0, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, BIAS,  1'b1, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, MAC,   1'b1, 1'b0, 0,  0, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, MAC,   1'b1, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, MAC,   1'b1, 1'b0, 2,  0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, WRITE, 1'b1, 1'b0, 0,  0, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(1'b0, BIAS,  1'b1, 1'b0, 0,  1, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, MAC,   1'b1, 1'b0, 0,  1, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, MAC,   1'b1, 1'b0, 1,  1, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, MAC,   1'b1, 1'b0, 2,  1, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, WRITE, 1'b1, 1'b0, 0,  1, 1'b0, 1'b1, 1'b1);
    vecs[11] = mk(1'b1, DONE,  1'b1, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, IDLE,  1'b0, 1'b0, 0,  0, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, IDLE,  1'b0, 1'b0, 0,  0, 1'b0, 1'b1, 1'b0);

    // Reset state while rst is held.
    #1;
    check_reset_outputs("reset");
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
    check("reset stall_cnt", int'(stall_a), 0);
`endif
    check("reset S state", int'(st_s), int'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table: full layer, start re-pulsed in MAC and in DONE (both ignored).
    done_pulses = 0;
    foreach (vecs[k]) begin
      @(negedge clk);
      start    = vecs[k].start;
      wr_ready = vecs[k].wr_ready;
      clk_en   = vecs[k].clk_en;
      #1;
      if (done_a) done_pulses++;
      check($sformatf("vec%0d state", k),   int'(st_a),   int'(vecs[k].st));
      check($sformatf("vec%0d busy", k),    int'(busy_a), int'(vecs[k].busy));
      check($sformatf("vec%0d done", k),    int'(done_a), int'(vecs[k].done));
      check($sformatf("vec%0d in_addr", k), int'(in_a),   int'(vecs[k].in_a));
      if (vecs[k].chk_neu)
        check($sformatf("vec%0d neu", k),   int'(neu_a),  int'(vecs[k].neu));
      check($sformatf("vec%0d bias", k),    int'(ub_a),   int'(vecs[k].ub));
      check($sformatf("vec%0d acc_clr", k), int'(clr_a),  int'(vecs[k].clr));
      check($sformatf("vec%0d wr_en", k),   int'(wen_a),  int'(vecs[k].wen));
    end
    start = 1'b0;
    check("table done pulses", done_pulses, 1);

    // Plain run: done 2*(3+2)+1 = 11 cycles after start.
    run_layer(1000, 0, 1000, 0, 0, cyc);
    check("latency plain", cyc, 11);

    // wr_ready low 4 cycles in first WRITE: done delayed by 4.
    run_layer(5, 4, 1000, 0, 0, cyc);
    check("latency stall", cyc, 15);
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
    check("stall_cnt after stall", int'(stall_a), 4);
`endif

    // Next layer clears the stall counter on start.
    run_layer(1000, 0, 1000, 0, 0, cyc);
    check("latency after stall", cyc, 11);
`ifdef LAYER_SCHEDULER_STALL_CNT_EN
    check("stall_cnt cleared", int'(stall_a), 0);
`endif

    // clk_en low 3 cycles while in_addr=1: done delayed by 3.
    run_layer(1000, 0, 3, 3, 1, cyc);
    check("latency freeze", cyc, 14);

    // Reset during BIAS of neuron 1 (cycle 6 after start).
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre-reset state", int'(st_a),  int'(BIAS));
    check("pre-reset neu",   int'(neu_a), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst = 1'b0;
    done_pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (done_a || busy_a) done_pulses++;
    end
    check("no activity after reset", done_pulses, 0);
    run_layer(1000, 0, 1000, 0, 0, cyc);
    check("latency after reset", cyc, 11);

    // Single input, single neuron: BIAS, MAC, WRITE, DONE, IDLE.
    exp_s[0] = BIAS;
    exp_s[1] = MAC;
    exp_s[2] = WRITE;
    exp_s[3] = DONE;
    exp_s[4] = IDLE;
    @(negedge clk);
    start_s = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_s = 1'b0;
      #1;
      check($sformatf("S cyc%0d state", c), int'(st_s),   int'(exp_s[c-1]));
      check($sformatf("S cyc%0d done", c),  int'(done_s), (c == 4) ? 1 : 0);
      check($sformatf("S cyc%0d wr_en", c), int'(wen_s),  (c == 3) ? 1 : 0);
      check($sformatf("S cyc%0d bias", c),  int'(ub_s),   (c == 1) ? 1 : 0);
      check($sformatf("S cyc%0d in", c),    int'(in_s),   0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, meaning inputs per neuron (>=1).
REQ-002 SHALL have parameter NUM_NEURONS, default 2, meaning neurons time-multiplexed on one MAC datapath (>=1).
REQ-003 SHALL have parameter IN_AW, default 1, meaning in_addr width (>= clog2(NUM_INPUTS), min 1).
REQ-004 SHALL have parameter NEU_AW, default 1, meaning neu_addr width (>= clog2(NUM_NEURONS), min 1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port clk_en  input  1  global enable; all state holds when low.
REQ-008 SHALL have port start  input  1  request to evaluate the whole layer.
REQ-009 SHALL have port wr_ready  input  1  result sink can accept a neuron result.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the layer completes.
REQ-012 SHALL have port in_addr  output  IN_AW  input/weight select for the MAC.
REQ-013 SHALL have port neu_addr  output  NEU_AW  neuron (weight bank/bias/result slot) select.
REQ-014 SHALL have port use_bias  output  1  MAC adder takes bias instead of product.
REQ-015 SHALL have port acc_clr  output  1  synchronous clear of the accumulator register.
REQ-016 SHALL have port wr_en  output  1  write activated accumulator result to slot neu_addr.

Function
REQ-017 SHALL implement states IDLE, BIAS, MAC, WRITE, DONE; all transitions only on clk edges with clk_en=1.
REQ-018 IDLE: acc_clr=1, other strobes 0; start=1 -> BIAS with neu_addr=0, in_addr=0.
REQ-019 BIAS: use_bias=1 for exactly one cycle -> MAC.
REQ-020 MAC: in_addr steps 0..NUM_INPUTS-1, one per cycle; at in_addr=NUM_INPUTS-1 -> WRITE, in_addr wraps to 0.
REQ-021 WRITE: wr_en=wr_ready; wr_ready=0 holds WRITE with accumulator and addresses unchanged (no acc_clr).
REQ-022 WRITE with wr_ready=1: acc_clr=1 same cycle; if neu_addr=NUM_NEURONS-1 -> DONE, else neu_addr+1 -> BIAS.
REQ-023 DONE: done=1 one cycle, neu_addr returns to 0 -> IDLE.
REQ-024 Latency with wr_ready held high: done asserted exactly NUM_NEURONS*(NUM_INPUTS+2)+1 cycles after the start-sampling cycle.
REQ-025 start while busy=1 SHALL be ignored (no queuing); start in the DONE cycle ignored.
REQ-026 clk_en=0 SHALL freeze state, counters and outputs at their current values.
REQ-027 NUM_INPUTS=1 SHALL give a single MAC cycle; NUM_NEURONS=1 SHALL go WRITE -> DONE directly.
REQ-028 All outputs SHALL be decoded from registered state/counters only (no combinational path from start; wr_en from wr_ready only).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, in_addr=0, neu_addr=0, busy=0, done=0, use_bias=0, wr_en=0, acc_clr=1.
REQ-030 Reset mid-layer SHALL abandon the layer with no done pulse; next start restarts at neuron 0.

Configuration
REQ-031 Macro LAYER_SCHEDULER_STALL_CNT_EN defined: add output stall_cnt (16 bit) counting cycles in WRITE with wr_ready=0 and clk_en=1, saturating at 0xFFFF, cleared on start accepted and on rst.
REQ-032 Macro undefined: no stall_cnt port or counter; all other behaviour identical.

Structure
REQ-033 State encoding (IDLE=0..DONE=4) as a typedef in shared package layer_sched_pkg, with STALL_CNT_W=16.
REQ-034 One sub-module index_counter (clear, inc, wrap at parameter MAX, last flag) SHALL be instantiated for in_addr and neu_addr.

Verification
REQ-035 NUM_INPUTS=3, NUM_NEURONS=2, wr_ready=1, start pulse -> in_addr 0,1,2 per neuron, wr_en at neu 0 then 1, done 11 cycles after start.
REQ-036 wr_ready low 4 cycles in first WRITE -> WRITE held 5 cycles, done delayed by 4, stall_cnt=4 with macro.
REQ-037 start re-pulsed during MAC -> ignored; exactly one done pulse.
REQ-038 clk_en low 3 cycles mid-MAC -> in_addr frozen, done delayed by 3.
REQ-039 rst asserted in BIAS of neuron 1 -> immediate IDLE, addrs 0, no done; following start completes normally.
REQ-040 NUM_INPUTS=1, NUM_NEURONS=1 -> BIAS, MAC, WRITE, DONE; done 4 cycles after start.
